// File: rtl/d_mem_responder_pkg.sv
// Shared definitions for the data-memory responder.
//   state_e      : FSM encoding (IDLE/WAIT/RESP, 2 bits)
//   WAIT_CNT_W   : width of the wait-state down-counter
//   RSP_ERR/OK   : values driven on rsp_error
//   merge_be     : byte-enable merge of store data into a stored word
//   addr_bad     : misaligned / out-of-range check for a byte address
package d_mem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int WAIT_CNT_W = 4;

  localparam logic RSP_ERR = 1'b1;
  localparam logic RSP_OK  = 1'b0;

  function automatic logic [31:0] merge_be(input logic [31:0] old_w,
                                           input logic [31:0] new_w,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_w;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

  // An address is bad when it is not word aligned or any bit above the
  // word-index field is set (no aliasing into the array).
  function automatic logic addr_bad(input logic [31:0] addr,
                                    input int unsigned addr_w);
    return (addr[1:0] != 2'b00) || ((addr >> (addr_w + 2)) != 32'd0);
  endfunction

endpackage

// File: rtl/d_mem_responder_wait_counter.sv
// Loadable wait-state down-counter.
//   clk_i      : clock, rising edge
//   rst_ni     : asynchronous reset, active low (count cleared to 0)
//   load_i     : load load_val_i (has priority over dec_i)
//   load_val_i : value to load
//   dec_i      : decrement by one, saturating at zero
//   is_one_o   : count currently equals one (last wait state)
module d_mem_responder_wait_counter
  import d_mem_responder_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  load_i,
  input  logic [WAIT_CNT_W-1:0] load_val_i,
  input  logic                  dec_i,
  output logic                  is_one_o
);

  logic [WAIT_CNT_W-1:0] cnt_q;
  logic [WAIT_CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - WAIT_CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign is_one_o = (cnt_q == WAIT_CNT_W'(1));

endmodule

// File: rtl/d_mem_responder.sv
// Slave end of the core's data-memory port: word-organised RAM answering
// load/store requests over valid/ready with WAIT_CYCLES wait states.
//   clock      : clock, rising edge
//   reset      : asynchronous reset, active low
//   req_valid  : request present          req_ready : accept this cycle (IDLE)
//   req_write  : 1 store / 0 load         req_addr  : byte address
//   req_wdata  : store data               req_be    : store byte enables
//   rsp_valid  : response present         rsp_ready : response consumed
//   rsp_rdata  : load data (0 for stores and errors)
//   rsp_error  : misaligned or out-of-range access
module d_mem_responder
  import d_mem_responder_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_CYCLES);
  localparam bit                    NO_WAIT   = (WAIT_CYCLES == 0);

  state_e      state_q;
  logic        rsp_valid_q;
  logic        rsp_error_q;
  logic [31:0] rsp_rdata_q;

  logic        wr_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;

  logic [31:0] mem_q [2**ADDR_W];

  logic              accept;
  logic              cnt_is_one;
  logic              commit;
  logic              mem_we;
  logic              acc_write;
  logic              acc_bad;
  logic [31:0]       acc_addr;
  logic [31:0]       acc_wdata;
  logic [3:0]        acc_be;
  logic [ADDR_W-1:0] acc_idx;
  logic [31:0]       rd_word;

  assign req_ready = (state_q == ST_IDLE);
  assign accept    = req_ready & req_valid;

  // With zero wait states the access commits on the accept edge itself, so
  // it must use the live request inputs instead of the capture registers.
  always_comb begin
    acc_write = wr_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    acc_be    = be_q;
    if (state_q == ST_IDLE) begin
      acc_write = req_write;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
      acc_be    = req_be;
    end
  end

  assign acc_idx = acc_addr[ADDR_W+1:2];
  assign acc_bad = addr_bad(acc_addr, ADDR_W);

  // The edge entering RESP is the commit point. Gating with reset keeps a
  // store from landing while reset is held (the RAM itself has no reset).
  assign commit  = reset & ((NO_WAIT & accept) |
                            ((state_q == ST_WAIT) & cnt_is_one));
  assign mem_we  = commit & acc_write & ~acc_bad;
  assign rd_word = (acc_bad | acc_write) ? 32'd0 : mem_q[acc_idx];

  d_mem_responder_wait_counter u_wait_counter (
    .clk_i      (clock),
    .rst_ni     (reset),
    .load_i     (accept),
    .load_val_i (WAIT_LOAD),
    .dec_i      (state_q == ST_WAIT),
    .is_one_o   (cnt_is_one)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_error_q <= RSP_OK;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (NO_WAIT) begin
              state_q     <= ST_RESP;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= rd_word;
              rsp_error_q <= acc_bad ? RSP_ERR : RSP_OK;
            end else begin
              state_q <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_is_one) begin
            state_q     <= ST_RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= rd_word;
            rsp_error_q <= acc_bad ? RSP_ERR : RSP_OK;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_error_q <= RSP_OK;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Request capture: data only, no reset needed.
  always_ff @(posedge clock) begin
    if (accept) begin
      wr_q    <= req_write;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      be_q    <= req_be;
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem_q[acc_idx] <= merge_be(mem_q[acc_idx], acc_wdata, acc_be);
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_error = rsp_error_q;

endmodule

// File: tb/tb_d_mem_responder.sv
module tb_d_mem_responder;

  localparam int W2 = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_ready;
  logic        sel;

  logic        r2_req_ready, r2_rsp_valid, r2_rsp_error;
  logic [31:0] r2_rsp_rdata;
  logic        r0_req_ready, r0_rsp_valid, r0_rsp_error;
  logic [31:0] r0_rsp_rdata;

  logic        m_req_ready, m_rsp_valid, m_rsp_error;
  logic [31:0] m_rsp_rdata;

  logic        req_valid2, req_valid0, rsp_ready2, rsp_ready0;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [2][256];

  always #5 clock = ~clock;

  assign req_valid2 = req_valid & ~sel;
  assign req_valid0 = req_valid & sel;
  assign rsp_ready2 = rsp_ready & ~sel;
  assign rsp_ready0 = rsp_ready & sel;

  assign m_req_ready = sel ? r0_req_ready : r2_req_ready;
  assign m_rsp_valid = sel ? r0_rsp_valid : r2_rsp_valid;
  assign m_rsp_rdata = sel ? r0_rsp_rdata : r2_rsp_rdata;
  assign m_rsp_error = sel ? r0_rsp_error : r2_rsp_error;

  d_mem_responder #(.ADDR_W(8), .WAIT_CYCLES(W2)) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid2),
    .req_ready (r2_req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (r2_rsp_valid),
    .rsp_ready (rsp_ready2),
    .rsp_rdata (r2_rsp_rdata),
    .rsp_error (r2_rsp_error)
  );

  d_mem_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) dut_w0 (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid0),
    .req_ready (r0_req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (r0_rsp_valid),
    .rsp_ready (rsp_ready0),
    .rsp_rdata (r0_rsp_rdata),
    .rsp_error (r0_rsp_error)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic is_bad(input logic [31:0] addr);
    return (addr[1:0] != 2'b00) || (addr[31:10] != 22'd0);
  endfunction

  task automatic model_store(input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] be);
    int m;
    m = sel ? 1 : 0;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) model[m][addr[9:2]][8*i +: 8] = wdata[8*i +: 8];
    end
  endtask

  // Drive one request and wait for it to be accepted; ok=0 on timeout.
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, output bit ok);
    @(negedge clock);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (m_req_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock);
    end
    check("accept", {31'd0, ok}, 32'd1);
    if (ok) @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
  endtask

  task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input int hold, input bit pulse);
    exp_t e;
    bit   ok;
    int   lat;
    int   m;
    m = sel ? 1 : 0;
    if (is_bad(addr)) begin
      e.rdata = 32'd0;
      e.err   = 1'b1;
    end else if (wr) begin
      model_store(addr, wdata, be);
      e.rdata = 32'd0;
      e.err   = 1'b0;
    end else begin
      e.rdata = model[m][addr[9:2]];
      e.err   = 1'b0;
    end
    sb.push_back(e);

    issue(wr, addr, wdata, be, ok);
    if (!ok) begin
      void'(sb.pop_front());
      return;
    end

    // Now at the first negedge after the accept edge.
    lat = 1;
    ok  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (m_rsp_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock);
      lat++;
    end
    check("rsp_seen", {31'd0, ok}, 32'd1);
    e = sb.pop_front();
    if (!ok) return;
    check("latency", lat, sel ? 32'd1 : 32'(W2 + 1));
    check("rdata", m_rsp_rdata, e.rdata);
    check("error", {31'd0, m_rsp_error}, {31'd0, e.err});
    check("busy_ready", {31'd0, m_req_ready}, 32'd0);

    for (int h = 0; h < hold; h++) begin
      @(negedge clock);
      if (pulse && h == 1) begin
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h10;
        req_wdata = 32'hFFFF_FFFF;
        req_be    = 4'hF;
      end else begin
        req_valid = 1'b0;
      end
      check("hold_valid", {31'd0, m_rsp_valid}, 32'd1);
      check("hold_rdata", m_rsp_rdata, e.rdata);
      check("hold_error", {31'd0, m_rsp_error}, {31'd0, e.err});
      check("hold_ready", {31'd0, m_req_ready}, 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    rsp_ready = 1'b0;
    check("post_valid", {31'd0, m_rsp_valid}, 32'd0);
    check("post_rdata", m_rsp_rdata, 32'd0);
    check("post_error", {31'd0, m_rsp_error}, 32'd0);
    check("post_ready", {31'd0, m_req_ready}, 32'd1);
  endtask

  // Start a request and assert reset either while it waits (in_resp=0,
  // one cycle after accept) or once its response is showing (in_resp=1).
  task automatic start_and_reset(input logic wr, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] be,
                                 input bit in_resp);
    bit ok;
    issue(wr, addr, wdata, be, ok);
    if (in_resp) begin
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
        if (m_rsp_valid) begin
          ok = 1'b1;
          break;
        end
        @(negedge clock);
      end
      check("rst_rsp_seen", {31'd0, ok}, 32'd1);
      if (wr && !is_bad(addr)) model_store(addr, wdata, be);
    end else begin
      check("rst_busy_ready", {31'd0, m_req_ready}, 32'd0);
    end
    reset = 1'b0;
    #1;
    check("rst_ready", {31'd0, m_req_ready}, 32'd1);
    check("rst_valid", {31'd0, m_rsp_valid}, 32'd0);
    check("rst_rdata", m_rsp_rdata, 32'd0);
    check("rst_error", {31'd0, m_rsp_error}, 32'd0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (4) @(negedge clock);
    check("rst_after_valid", {31'd0, m_rsp_valid}, 32'd0);
  endtask

  initial begin
    reset     = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = 32'd0;
    req_wdata = 32'd0;
    req_be    = 4'h0;
    rsp_ready = 1'b0;
    sel       = 1'b0;
    repeat (3) @(negedge clock);
    check("init_ready", {31'd0, m_req_ready}, 32'd1);
    check("init_valid", {31'd0, m_rsp_valid}, 32'd0);
    check("init_rdata", m_rsp_rdata, 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // Full store then load.
    do_req(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 1'b0);
    do_req(1'b0, 32'h10, 32'h0,         4'h0, 0, 1'b0);

    // Reset while a load response is being presented.
    start_and_reset(1'b0, 32'h10, 32'h0, 4'h0, 1'b1);

    // Partial store replaces byte 1 only.
    do_req(1'b1, 32'h10, 32'h0000_AA00, 4'b0010, 0, 1'b0);
    do_req(1'b0, 32'h10, 32'h0,         4'h0,    0, 1'b0);

    // Store with no byte enables leaves the word alone.
    do_req(1'b1, 32'h10, 32'hFFFF_FFFF, 4'h0, 0, 1'b0);
    do_req(1'b0, 32'h10, 32'h0,         4'h0, 0, 1'b0);

    // Errors: misaligned load, out-of-range store aliasing word 0.
    do_req(1'b1, 32'h0,   32'h1111_1111, 4'hF, 0, 1'b0);
    do_req(1'b0, 32'h12,  32'h0,         4'h0, 0, 1'b0);
    do_req(1'b1, 32'h400, 32'h5555_5555, 4'hF, 0, 1'b0);
    do_req(1'b0, 32'h0,   32'h0,         4'h0, 0, 1'b0);

    // Backpressure with a stray request pulsed during the response.
    do_req(1'b0, 32'h10, 32'h0, 4'h0, 5, 1'b1);
    do_req(1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0);

    // Reset during the wait states of a store: it must never land.
    do_req(1'b1, 32'h20, 32'hCAFE_F00D, 4'hF, 0, 1'b0);
    start_and_reset(1'b1, 32'h20, 32'h1234_5678, 4'hF, 1'b0);
    do_req(1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b0);

    // Zero-wait-state build.
    sel = 1'b1;
    @(negedge clock);
    do_req(1'b1, 32'h8, 32'hABCD_0123, 4'hF, 0, 1'b0);
    do_req(1'b0, 32'h8, 32'h0,         4'h0, 0, 1'b0);
    do_req(1'b0, 32'h9, 32'h0,         4'h0, 2, 1'b0);
    sel = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
